// File: rtl/skullfet_chain_tester.sv
// skullfet_chain_tester
// Drives a bank of SkullFET inverter channels through a fixed pattern set
// (all-0, all-1, walking-one, walking-zero) and checks dut_y == ~dut_a for
// each pattern after a programmable settle time.
// Optional build macro: SKULLFET_SYNC_EN -- routes dut_y through a 2-flop
// synchroniser before comparison and stretches every settle window by the
// two extra cycles the synchroniser needs to deliver the new value.
module skullfet_chain_tester #(
    parameter int CHANNELS = 4,
    parameter int SETTLE_W = 8,
    parameter int ERR_W    = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic [CHANNELS-1:0] dut_a,
    input  logic [CHANNELS-1:0] dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [CHANNELS-1:0] fail_mask
);

    localparam int NPAT  = 2 + 2 * CHANNELS;
    localparam int IDX_W = $clog2(NPAT);
    localparam int CNT_W = SETTLE_W + 2;
    localparam int SUM_W = ERR_W + 7;
`ifdef SKULLFET_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CHANNELS-1:0] r_dut_a,     w_dut_a_nxt;
    logic                r_busy,      w_busy_nxt;
    logic                r_done,      w_done_nxt;
    logic                r_pass,      w_pass_nxt;
    logic [ERR_W-1:0]    r_err,       w_err_nxt;
    logic [CHANNELS-1:0] r_fail_mask, w_fail_mask_nxt;
    logic [IDX_W-1:0]    r_pat_idx,   w_pat_idx_nxt;
    logic [CNT_W-1:0]    r_settle_cnt, w_settle_cnt_nxt;
    logic [SETTLE_W-1:0] r_settle_lat, w_settle_lat_nxt;

    logic [CHANNELS-1:0] w_y_sampled;
    logic [CHANNELS-1:0] w_mismatch;
    logic [CHANNELS-1:0] w_fail_mask_upd;
    logic [SUM_W-1:0]    w_err_sum;
    logic [ERR_W-1:0]    w_err_sat;
    logic                w_last_pat;

    // Test pattern for a given index: all-0, all-1, walking-one, walking-zero.
    function automatic logic [CHANNELS-1:0] pattern_at(input logic [IDX_W-1:0] idx);
        int k;
        logic [CHANNELS-1:0] one;
        k   = int'(idx);
        one = CHANNELS'(1'b1);
        if (k == 0) begin
            pattern_at = {CHANNELS{1'b0}};
        end else if (k == 1) begin
            pattern_at = {CHANNELS{1'b1}};
        end else if (k < 2 + CHANNELS) begin
            pattern_at = one << (k - 2);
        end else begin
            pattern_at = ~(one << (k - 2 - CHANNELS));
        end
    endfunction

    // Number of set bits in a channel vector (at most 32, fits in 7 bits).
    function automatic logic [6:0] popcount(input logic [CHANNELS-1:0] v);
        logic [6:0] acc;
        acc = 7'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            acc = acc + {6'd0, v[i]};
        end
        return acc;
    endfunction

    // Settle-counter load value: settle+1 cycles, plus synchroniser latency.
    function automatic logic [CNT_W-1:0] settle_reload(input logic [SETTLE_W-1:0] s);
        return CNT_W'(s) + CNT_W'(SYNC_EXTRA);
    endfunction

`ifdef SKULLFET_SYNC_EN
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    // Two-flop synchroniser bringing the asynchronous inverter outputs into wb_clk_i.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1 <= {CHANNELS{1'b0}};
            r_sync2 <= {CHANNELS{1'b0}};
        end else begin
            r_sync1 <= dut_y;
            r_sync2 <= r_sync1;
        end
    end

    assign w_y_sampled = r_sync2;
`else
    assign w_y_sampled = dut_y;
`endif

    // A channel mismatches when its output is not the inverse of its drive.
    assign w_mismatch      = w_y_sampled ^ ~r_dut_a;
    assign w_fail_mask_upd = r_fail_mask | w_mismatch;
    assign w_err_sum       = SUM_W'(r_err) + SUM_W'(popcount(w_mismatch));
    assign w_err_sat       = (w_err_sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}}
                                                                 : w_err_sum[ERR_W-1:0];
    assign w_last_pat      = (r_pat_idx == IDX_W'(NPAT - 1));

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (w_last_pat) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output / datapath next values; start is only acted on outside a run.
    always_comb begin
        w_dut_a_nxt      = r_dut_a;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_pass_nxt       = r_pass;
        w_err_nxt        = r_err;
        w_fail_mask_nxt  = r_fail_mask;
        w_pat_idx_nxt    = r_pat_idx;
        w_settle_cnt_nxt = r_settle_cnt;
        w_settle_lat_nxt = r_settle_lat;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_dut_a_nxt      = pattern_at({IDX_W{1'b0}});
                    w_busy_nxt       = 1'b1;
                    w_done_nxt       = 1'b0;
                    w_pass_nxt       = 1'b0;
                    w_err_nxt        = {ERR_W{1'b0}};
                    w_fail_mask_nxt  = {CHANNELS{1'b0}};
                    w_pat_idx_nxt    = {IDX_W{1'b0}};
                    w_settle_lat_nxt = settle_cycles;
                    w_settle_cnt_nxt = settle_reload(settle_cycles);
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt != {CNT_W{1'b0}}) begin
                    w_settle_cnt_nxt = r_settle_cnt - CNT_W'(1'b1);
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt;
                end
            end
            ST_SAMPLE: begin
                w_fail_mask_nxt = w_fail_mask_upd;
                w_err_nxt       = w_err_sat;
                if (w_last_pat) begin
                    w_dut_a_nxt = {CHANNELS{1'b0}};
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_fail_mask_upd == {CHANNELS{1'b0}});
                end else begin
                    w_pat_idx_nxt    = r_pat_idx + IDX_W'(1'b1);
                    w_dut_a_nxt      = pattern_at(r_pat_idx + IDX_W'(1'b1));
                    w_settle_cnt_nxt = settle_reload(r_settle_lat);
                end
            end
            default: begin
                w_dut_a_nxt = {CHANNELS{1'b0}};
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
                w_pass_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dut_a      <= {CHANNELS{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= {ERR_W{1'b0}};
            r_fail_mask  <= {CHANNELS{1'b0}};
            r_pat_idx    <= {IDX_W{1'b0}};
            r_settle_cnt <= {CNT_W{1'b0}};
            r_settle_lat <= {SETTLE_W{1'b0}};
        end else begin
            r_dut_a      <= w_dut_a_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err        <= w_err_nxt;
            r_fail_mask  <= w_fail_mask_nxt;
            r_pat_idx    <= w_pat_idx_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_settle_lat <= w_settle_lat_nxt;
        end
    end

    assign dut_a     = r_dut_a;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_skullfet_chain_tester.sv
// Self-checking bench for skullfet_chain_tester: randomised fault masks and
// settle values checked against a pattern-level reference model.
module tb_skullfet_chain_tester;

`ifdef SKULLFET_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    localparam int NPAT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] settle = 8'd0;
    logic [7:0] settle2 = 8'd0;
    logic [3:0] dut_a, dut_y, a2, y2, fail_mask, fm2;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [15:0] err;
    logic [1:0]  err2;
    logic [3:0]  s0 = 4'd0;
    logic [3:0]  s1 = 4'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Inverter bank model with optional stuck-at-0 / stuck-at-1 channels.
    assign dut_y = (~dut_a & ~s0) | s1;
    assign y2    = 4'b0000;

    skullfet_chain_tester #(.CHANNELS(4), .SETTLE_W(8), .ERR_W(16)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .settle_cycles(settle),
        .dut_a(dut_a), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
        .err_count(err), .fail_mask(fail_mask));

    skullfet_chain_tester #(.CHANNELS(4), .SETTLE_W(8), .ERR_W(2)) u_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .settle_cycles(settle2),
        .dut_a(a2), .dut_y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(fm2));

    // Expected pattern sequence built from the rule list.
    function automatic logic [3:0] pat(input int p);
        logic [3:0] q [$];
        q.push_back(4'h0);
        q.push_back(4'hF);
        for (int i = 0; i < 4; i++) q.push_back(4'(1 << i));
        for (int i = 0; i < 4; i++) q.push_back(~4'(1 << i));
        return q[p];
    endfunction

    // Reference result of one full run for given stuck masks.
    task automatic model(input logic [3:0] m0, input logic [3:0] m1, input int errmax,
                         output int e, output logic [3:0] mask);
        logic [3:0] a, y, mm;
        e = 0;
        mask = 4'd0;
        for (int p = 0; p < NPAT; p++) begin
            a = pat(p);
            y = (~a & ~m0) | m1;
            mm = y ^ ~a;
            mask |= mm;
            e += $countones(mm);
            if (e > errmax) e = errmax;
        end
    endtask

    // Start a run on the main instance and follow it until busy drops.
    task automatic run_main(input int st, input int restart_at,
                            output int cycles, output int seq_bad);
        int per;
        per = st + 2 + SYNC_EXTRA;
        @(negedge clk);
        settle = 8'(st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        seq_bad = 0;
        while (busy === 1'b1 && cycles < 5000) begin
            if (cycles / per >= NPAT) seq_bad++;
            else if (dut_a !== pat(cycles / per)) seq_bad++;
            cycles++;
            settle = 8'($urandom_range(0, 255));
            start = (cycles == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (dut_a !== 4'd0) begin errors++; $display("FAIL reset_dut_a: got %h expected 0", dut_a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
        checks++; if (err !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
        checks++; if (fail_mask !== 4'd0) begin errors++; $display("FAIL reset_mask: got %h expected 0", fail_mask); end
        rst = 1'b0;
    endtask

    task automatic test_ideal;
        int cyc, bad;
        s0 = 4'd0; s1 = 4'd0;
        run_main(3, -1, cyc, bad);
        checks++; if (cyc != 10 * (5 + SYNC_EXTRA)) begin errors++; $display("FAIL ideal_busy_len: got %0d expected %0d", cyc, 10 * (5 + SYNC_EXTRA)); end
        checks++; if (bad != 0) begin errors++; $display("FAIL ideal_pattern_seq: got %0d bad cycles expected 0", bad); end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL ideal_done_pass: got %b%b expected 11", done, pass); end
        checks++; if (err !== 16'd0 || fail_mask !== 4'd0) begin errors++; $display("FAIL ideal_err_mask: got %0d/%h expected 0/0", err, fail_mask); end
        checks++; if (dut_a !== 4'd0) begin errors++; $display("FAIL ideal_dut_a_idle: got %h expected 0", dut_a); end
        repeat (7) @(negedge clk);
        checks++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_hold: got done=%b pass=%b busy=%b expected 1 1 0", done, pass, busy); end
    endtask

    task automatic test_stuck_bit2;
        int cyc, bad;
        s0 = 4'b0100; s1 = 4'd0;
        run_main(3, -1, cyc, bad);
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL stuck2_done_pass: got %b%b expected 10", done, pass); end
        checks++; if (err !== 16'd5) begin errors++; $display("FAIL stuck2_err: got %0d expected 5", err); end
        checks++; if (fail_mask !== 4'b0100) begin errors++; $display("FAIL stuck2_mask: got %b expected 0100", fail_mask); end
    endtask

    task automatic test_random;
        int cyc, bad, st, e;
        logic [3:0] m;
        for (int it = 0; it < 8; it++) begin
            st = $urandom_range(0, 6);
            s0 = 4'($urandom);
            s1 = 4'($urandom) & ~s0;
            if (it == 0) begin s0 = 4'd0; s1 = 4'd0; end
            model(s0, s1, 65535, e, m);
            run_main(st, -1, cyc, bad);
            checks++; if (cyc != NPAT * (st + 2 + SYNC_EXTRA)) begin errors++; $display("FAIL rand_busy_len: got %0d expected %0d", cyc, NPAT * (st + 2 + SYNC_EXTRA)); end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_pattern_seq: got %0d bad cycles expected 0", bad); end
            checks++; if (err !== 16'(e)) begin errors++; $display("FAIL rand_err: got %0d expected %0d", err, e); end
            checks++; if (fail_mask !== m) begin errors++; $display("FAIL rand_mask: got %b expected %b", fail_mask, m); end
            checks++; if (done !== 1'b1 || pass !== (m == 4'd0)) begin errors++; $display("FAIL rand_done_pass: got %b%b expected 1%b", done, pass, (m == 4'd0)); end
        end
    endtask

    task automatic test_restart_ignored;
        int cyc, bad;
        s0 = 4'd0; s1 = 4'd0;
        run_main(3, 20, cyc, bad);
        checks++; if (cyc != 10 * (5 + SYNC_EXTRA)) begin errors++; $display("FAIL restart_busy_len: got %0d expected %0d", cyc, 10 * (5 + SYNC_EXTRA)); end
        checks++; if (bad != 0) begin errors++; $display("FAIL restart_pattern_seq: got %0d bad cycles expected 0", bad); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL restart_pass: got %b expected 1", pass); end
    endtask

    task automatic test_reset_midrun;
        int n, cyc, bad;
        s0 = 4'b0001; s1 = 4'd0;
        @(negedge clk);
        settle = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
        checks++; if (err === 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL midrun_prereq: got err=%0d busy=%b expected err>0 busy=1", err, busy); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({busy, done, pass} !== 3'b000 || dut_a !== 4'd0 || err !== 16'd0 || fail_mask !== 4'd0)
            begin errors++; $display("FAIL midrun_reset: got busy=%b done=%b pass=%b a=%h err=%0d mask=%h expected all 0", busy, done, pass, dut_a, err, fail_mask); end
        @(negedge clk);
        rst = 1'b0;
        s0 = 4'd0;
        run_main(3, -1, cyc, bad);
        checks++; if (cyc != 10 * (5 + SYNC_EXTRA) || pass !== 1'b1) begin errors++; $display("FAIL post_reset_run: got len=%0d pass=%b expected %0d 1", cyc, pass, 10 * (5 + SYNC_EXTRA)); end
    endtask

    task automatic test_saturate;
        int n;
        @(negedge clk);
        settle2 = 8'd0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 5000) begin n++; @(negedge clk); end
        checks++; if (n != NPAT * (2 + SYNC_EXTRA)) begin errors++; $display("FAIL sat_busy_len: got %0d expected %0d", n, NPAT * (2 + SYNC_EXTRA)); end
        checks++; if (err2 !== 2'd3) begin errors++; $display("FAIL sat_err: got %0d expected 3", err2); end
        checks++; if (fm2 !== 4'b1111) begin errors++; $display("FAIL sat_mask: got %b expected 1111", fm2); end
        checks++; if (done2 !== 1'b1 || pass2 !== 1'b0) begin errors++; $display("FAIL sat_done_pass: got %b%b expected 10", done2, pass2); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck_bit2();
        test_restart_ignored();
        test_random();
        test_reset_midrun();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skullfet_chain_tester.md
SKULLFET_CHAIN_TESTER -- requirements
Module: skullfet_chain_tester

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of SkullFET inverter channels under test (1..32).
REQ-002 SHALL have parameter SETTLE_W, default 8: width of the settle-delay setting.
REQ-003 SHALL have parameter ERR_W, default 16: width of the error counter.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: single clock; all state on the rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a test run.
REQ-007 SHALL have port settle_cycles, input, SETTLE_W bits: extra settle cycles per pattern, sampled at start.
REQ-008 SHALL have port dut_a, output, CHANNELS bits: drives inverter inputs.
REQ-009 SHALL have port dut_y, input, CHANNELS bits: inverter outputs, asynchronous to wb_clk_i.
REQ-010 SHALL have port busy, output, 1 bit: run in progress.
REQ-011 SHALL have port done, output, 1 bit: run complete, held until next start or reset.
REQ-012 SHALL have port pass, output, 1 bit: done and no mismatch seen.
REQ-013 SHALL have port err_count, output, ERR_W bits: total mismatched channel-samples.
REQ-014 SHALL have port fail_mask, output, CHANNELS bits: sticky per-channel mismatch flags.

Function
REQ-015 SHALL step through fixed pattern order: all-0, all-1, walking-one (bit 0 first), walking-zero (bit 0 first): 2+2*CHANNELS patterns.
REQ-016 SHALL expect dut_y == ~dut_a for every pattern.
REQ-017 SHALL use states IDLE, SETTLE, SAMPLE, DONE.
REQ-018 IDLE/DONE + start: next cycle SETTLE, pattern 0 on dut_a, busy=1, done=0, err_count and fail_mask cleared, settle_cycles latched.
REQ-019 SETTLE SHALL last latched settle_cycles+1 cycles (plus sync latency per REQ-031), then go to SAMPLE.
REQ-020 SAMPLE (1 cycle) SHALL compare sampled dut_y with expected, OR mismatches into fail_mask, add popcount of mismatches to err_count.
REQ-021 After SAMPLE: next pattern -> SETTLE with new dut_a the same cycle; last pattern -> DONE.
REQ-022 err_count SHALL saturate at 2^ERR_W-1, never wrap.
REQ-023 DONE: busy=0, done=1, pass=(fail_mask==0); dut_a returns to 0.
REQ-024 start while busy SHALL be ignored with no side effects.
REQ-025 settle_cycles changes during a run SHALL have no effect.
REQ-026 pass SHALL be 0 whenever done is 0.

Reset
REQ-027 wb_rst_i asserted, at any time including mid-run, SHALL immediately force IDLE, dut_a=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, synchroniser flops=0.
REQ-028 First start SHALL be honoured on the first rising edge after wb_rst_i deasserts.

Configuration
REQ-029 Macro SKULLFET_SYNC_EN SHALL select the input sampling path.
REQ-030 Without SKULLFET_SYNC_EN: SAMPLE compares dut_y directly.
REQ-031 With SKULLFET_SYNC_EN: dut_y passes a 2-flop synchroniser; SAMPLE uses synchroniser output; SETTLE lengthened by exactly 2 cycles.

Verification
REQ-032 CHANNELS=4, settle_cycles=3, no macro, ideal model y=~a: start -> busy high 50 cycles, then done=1, pass=1, err_count=0, fail_mask=0.
REQ-033 Same, dut_y[2] stuck at 0 -> done=1, pass=0, err_count=5, fail_mask=4'b0100.
REQ-034 ERR_W=2, all dut_y stuck at 0 -> err_count=3 (saturated), fail_mask=4'b1111.
REQ-035 start pulsed again at cycle 20 of a run, then wb_rst_i pulsed at cycle 30 of a fresh run -> first ignored (50-cycle run unchanged); reset drives all outputs to 0 asynchronously, next start runs normally.
REQ-036 SKULLFET_SYNC_EN defined, settle_cycles=3, ideal model -> busy high 70 cycles, pass=1.
